// File: rtl/switch_input_ctrl_pkg.sv
// Shared I/O package: debounce FSM encoding and default settle length
// used by the switch input controller and its sibling I/O blocks.
package switch_input_ctrl_pkg;

  typedef enum logic {
    SW_IDLE   = 1'b0,
    SW_SETTLE = 1'b1
  } sw_state_e;

  localparam int SW_DEBOUNCE_CYCLES_DFLT = 500000;
  localparam int SW_WIDTH_DFLT           = 16;

endpackage

// File: rtl/switch_input_ctrl_sync.sv
// Two-flop synchronizer bringing asynchronous board levels into the clk domain.
module sync_2ff #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_d, sync1_q;
  logic [WIDTH-1:0] sync2_d, sync2_q;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/switch_input_ctrl.sv
// Switch debouncer: a candidate value must stay stable for DEBOUNCE_CYCLES
// samples before it replaces sw_data; sw_changed flags it until the CPU reads.
module switch_input_ctrl
  import switch_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DFLT,
  parameter int WIDTH           = SW_WIDTH_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             rd_en,
  output logic [WIDTH-1:0] sw_data,
  output logic             sw_changed,
  output logic             sw_busy
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync2;
  sw_state_e        state_d, state_q;
  logic [WIDTH-1:0] cand_d, cand_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic             changed_d, changed_q;
  logic             commit;

  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_raw),
    .q     (sync2)
  );

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    changed_d = changed_q;
    commit    = 1'b0;
    case (state_q)
      SW_IDLE: begin
        if (sync2 != data_q) begin
          cand_d  = sync2;
          cnt_d   = '0;
          state_d = SW_SETTLE;
        end
      end
      SW_SETTLE: begin
        // cand never equals data_q here, so a return to data_q is a bounce-back
        if (sync2 == data_q) begin
          state_d = SW_IDLE;
        end else if (sync2 != cand_q) begin
          cand_d = sync2;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          data_d  = cand_q;
          commit  = 1'b1;
          state_d = SW_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = SW_IDLE;
    endcase
    // a commit on the read edge keeps the flag: the CPU saw the old value
    if (rd_en)  changed_d = 1'b0;
    if (commit) changed_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SW_IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      changed_q <= changed_d;
    end
  end

  assign sw_data    = data_q;
  assign sw_changed = changed_q;
  assign sw_busy    = (state_q == SW_SETTLE);

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Bench for switch_input_ctrl with N=4; reference model counts consecutive
// identical synchronized samples instead of tracking FSM state.
module tb_switch_input_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic         rd_en;
  logic [W-1:0] sw_data;
  logic         sw_changed;
  logic         sw_busy;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [W-1:0] m_s1, m_s2, m_data, m_v;
  logic         m_chg;
  int           m_run;

  switch_input_ctrl #(.DEBOUNCE_CYCLES(N), .WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .rd_en      (rd_en),
    .sw_data    (sw_data),
    .sw_changed (sw_changed),
    .sw_busy    (sw_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge; the model accepts a value once it has been the
  // synchronized level on N+1 consecutive edges.
  task automatic tick();
    logic [W-1:0] s;
    logic         commit;
    @(posedge clk);
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_data = '0; m_v = '0; m_chg = 1'b0; m_run = 0;
    end else begin
      s = m_s2;
      commit = 1'b0;
      if (s == m_data) m_run = 0;
      else if (m_run > 0 && s == m_v) m_run++;
      else begin m_run = 1; m_v = s; end
      if (m_run == N + 1) begin m_data = s; m_run = 0; commit = 1'b1; end
      if (rd_en)  m_chg = 1'b0;
      if (commit) m_chg = 1'b1;
      m_s2 = m_s1;
      m_s1 = sw_raw;
    end
    #1;
  endtask

  task automatic do_reset(input logic [W-1:0] raw);
    sw_raw = raw; rd_en = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(16'hA5A5);
    total++; if (sw_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", sw_data); end
    total++; if (sw_changed !== 1'b0) begin bad++; $display("FAIL reset_changed got=%b exp=0", sw_changed); end
    total++; if (sw_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", sw_busy); end
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) begin
        total++; if (sw_data !== 16'h0000) begin bad++; $display("FAIL reset_early edge=%0d got=%h exp=0000", e, sw_data); end
      end
    end
    total++; if (sw_data !== 16'hA5A5) begin bad++; $display("FAIL reset_accept got=%h exp=a5a5", sw_data); end
    total++; if (sw_changed !== 1'b1) begin bad++; $display("FAIL reset_accept_chg got=%b exp=1", sw_changed); end
  endtask

  task automatic test_bounce();
    int commits;
    logic [W-1:0] prev;
    do_reset(16'h0000);
    commits = 0;
    prev = sw_data;
    for (int i = 0; i < 10; i++) begin
      sw_raw = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      tick();
      total++; if (sw_data !== 16'h0000) begin bad++; $display("FAIL bounce_toggle cyc=%0d got=%h exp=0000", i, sw_data); end
    end
    sw_raw = 16'h0001;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (sw_data !== prev) commits++;
      prev = sw_data;
      if (e < 7) begin
        total++; if (sw_data !== 16'h0000) begin bad++; $display("FAIL bounce_early edge=%0d got=%h exp=0000", e, sw_data); end
      end else if (e == 7) begin
        total++; if (sw_data !== 16'h0001) begin bad++; $display("FAIL bounce_commit got=%h exp=0001", sw_data); end
      end
    end
    total++; if (commits !== 1) begin bad++; $display("FAIL bounce_commits got=%0d exp=1", commits); end
  endtask

  task automatic test_bounce_back();
    logic busy_seen;
    do_reset(16'h0000);
    busy_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      sw_raw = (c < 2) ? 16'h00F0 : 16'h0000;
      tick();
      busy_seen |= sw_busy;
      total++; if (sw_data !== 16'h0000 || sw_changed !== 1'b0) begin
        bad++; $display("FAIL bounce_back cyc=%0d data=%h chg=%b exp data=0000 chg=0", c, sw_data, sw_changed);
      end
    end
    total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL bounce_back_busy got=%b exp=1", busy_seen); end
    total++; if (sw_busy !== 1'b0) begin bad++; $display("FAIL bounce_back_idle got=%b exp=0", sw_busy); end
  endtask

  task automatic test_read_clear();
    sw_raw = 16'h3C3C;
    for (int e = 0; e < 7; e++) tick();
    total++; if (sw_changed !== 1'b1) begin bad++; $display("FAIL rdclr_pre got=%b exp=1", sw_changed); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    total++; if (sw_changed !== 1'b0) begin bad++; $display("FAIL rdclr_flag got=%b exp=0", sw_changed); end
    total++; if (sw_data !== 16'h3C3C) begin bad++; $display("FAIL rdclr_data got=%h exp=3c3c", sw_data); end
  endtask

  task automatic test_commit_read_same_edge();
    sw_raw = 16'h5A01;
    for (int e = 0; e < 6; e++) tick();
    total++; if (sw_data !== 16'h3C3C) begin bad++; $display("FAIL simul_pre got=%h exp=3c3c", sw_data); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    total++; if (sw_changed !== 1'b1) begin bad++; $display("FAIL simul_flag got=%b exp=1", sw_changed); end
    total++; if (sw_data !== 16'h5A01) begin bad++; $display("FAIL simul_data got=%h exp=5a01", sw_data); end
  endtask

  task automatic test_reset_mid_settle();
    sw_raw = 16'h0F0F;
    for (int e = 0; e < 5; e++) tick();   // loaded at edge 3, cnt=2 after edge 5
    total++; if (sw_busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_pre got=%b exp=1", sw_busy); end
    reset = 1'b1; rd_en = 1'b1; tick(); reset = 1'b0; rd_en = 1'b0;
    total++; if (sw_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", sw_busy); end
    total++; if (sw_data !== 16'h0000) begin bad++; $display("FAIL midrst_data got=%h exp=0000", sw_data); end
    total++; if (sw_changed !== 1'b0) begin bad++; $display("FAIL midrst_chg got=%b exp=0", sw_changed); end
  endtask

  task automatic test_random();
    logic [W-1:0] pool [4];
    pool[0] = 16'h0000; pool[1] = 16'hA5A5; pool[2] = 16'h0001; pool[3] = 16'hFFFF;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(5) == 0)
        sw_raw = ($urandom_range(3) == 0) ? W'($urandom) : pool[$urandom_range(3)];
      rd_en = ($urandom_range(3) == 0);
      reset = ($urandom_range(99) == 0);
      tick();
      total++; if (sw_data !== m_data) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, sw_data, m_data); end
      total++; if (sw_changed !== m_chg) begin bad++; $display("FAIL rand_chg cyc=%0d got=%b exp=%b", c, sw_changed, m_chg); end
      total++; if (sw_busy !== (m_run != 0)) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, sw_busy, (m_run != 0)); end
    end
    reset = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd_en = 1'b0; sw_raw = '0;
    m_s1 = '0; m_s2 = '0; m_data = '0; m_v = '0; m_chg = 1'b0; m_run = 0;
    test_reset();
    test_bounce();
    test_bounce_back();
    test_read_clear();
    test_commit_read_same_edge();
    test_reset_mid_settle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_input_ctrl.md
SWITCH_INPUT_CTRL -- requirements
Module: switch_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, defining the number of stable cycles N required before a new switch value is accepted (legal range 2..2^20).
REQ-002 SHALL have parameter WIDTH, default 16, defining the number of switch bits.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 sw_raw  input  WIDTH  asynchronous board switch levels.
REQ-006 rd_en  input  1  read strobe: high when the CPU performs an I/O read with the switch port selected.
REQ-007 sw_data  output  WIDTH  debounced switch value, registered; feeds the I/O read mux.
REQ-008 sw_changed  output  1  sticky flag: a new value was committed since the last read.
REQ-009 sw_busy  output  1  high while a candidate value is settling.

Function
REQ-010 SHALL pass sw_raw through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-011 SHALL implement an FSM with states IDLE and SETTLE, plus a candidate register cand[WIDTH] and a settle counter cnt of ceil(log2(N)) bits.
REQ-012 IDLE: if sync2 != sw_data, load cand <= sync2 and cnt <= 0, then go to SETTLE; otherwise remain in IDLE.
REQ-013 SETTLE, sync2 == cand and cnt < N-1: increment cnt.
REQ-014 SETTLE, sync2 == cand and cnt == N-1: commit sw_data <= cand, set sw_changed, go to IDLE.
REQ-015 SETTLE, sync2 != cand and sync2 != sw_data: reload cand <= sync2 and clear cnt; remain in SETTLE (glitch restart).
REQ-016 SETTLE, sync2 == sw_data: go to IDLE with no commit (bounce back to the old value).
REQ-017 For a single clean change, sw_data SHALL update exactly N+3 rising edges after the edge that first samples the new sw_raw.
REQ-018 sw_busy SHALL equal 1 exactly when state == SETTLE.
REQ-019 A rising edge with rd_en=1 SHALL clear sw_changed.
REQ-020 If a commit and rd_en=1 occur on the same edge, sw_changed SHALL end set, because the new data wins.
REQ-021 sw_data SHALL change only on commit and SHALL never show a partially updated value.
REQ-022 The counter SHALL saturate logically at N-1 and never wrap.

Reset
REQ-023 On reset=1 at a rising edge, the block SHALL clear sync1, sync2, cand, cnt, sw_data and sw_changed to 0 and set state to IDLE, regardless of the current state, including mid-SETTLE.
REQ-024 After reset, a nonzero sw_raw SHALL be accepted through the normal settle path; it SHALL NOT be loaded directly.
REQ-025 Reset SHALL have priority over rd_en and over a commit.

Structure
REQ-026 The FSM state encoding and the DEBOUNCE_CYCLES default SHALL live in the shared I/O package used by the other I/O blocks.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, parameterized by WIDTH.
REQ-028 The design SHALL contain no latches, no combinational feedback, and a single clock domain after sync_2ff.

Verification (N=4 for simulation)
REQ-029 Reset with sw_raw=16'hA5A5 held: sw_data=0 and sw_changed=0 after reset; sw_data=16'hA5A5 exactly 7 edges after reset deasserts, sw_changed=1.
REQ-030 Bounce: sw_raw toggles 16'h0001/16'h0000 every cycle for 10 cycles, then holds 16'h0001: a single commit, 7 edges after the final hold, and sw_data is never 16'h0001 earlier.
REQ-031 Bounce-back: sw_raw=16'h00F0 for 2 cycles, then back to 16'h0000: sw_busy pulses, no commit, sw_changed stays 0.
REQ-032 Read clear: with sw_changed=1, pulse rd_en for one cycle: sw_changed=0 on the next edge and sw_data is unchanged.
REQ-033 Simultaneous commit and rd_en on the same edge: sw_changed=1 and sw_data holds the new value.
REQ-034 Reset asserted mid-SETTLE, with cnt=2: state=IDLE, sw_busy=0 and sw_data=0 on the next edge.
